// File: rtl/ledger_tx_driver.sv
// Traffic source for the ledger pipeline: issues LFSR-driven transfers, tallies the
// ledger's results and reports completion, drain timeouts and stray results.
module ledger_tx_driver #(
  parameter int USER_WIDTH    = 10,
  parameter int BALANCE_WIDTH = 64,
  parameter int AMOUNT_BITS   = 12,
  parameter int COUNT_WIDTH   = 32,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COUNT_WIDTH-1:0]   num_tx,
  input  logic [7:0]               gap,
  input  logic [31:0]              seed,
  output logic                     s_valid,
  output logic [USER_WIDTH-1:0]    s_payer,
  output logic [USER_WIDTH-1:0]    s_payee,
  output logic [BALANCE_WIDTH-1:0] s_amount,
  input  logic                     m_valid,
  input  logic                     m_success,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   sent_count,
  output logic [COUNT_WIDTH-1:0]   ok_count,
  output logic [COUNT_WIDTH-1:0]   fail_count,
  output logic                     err_timeout,
  output logic                     err_stray
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [31:0]            lfsr_r;
  logic [7:0]             gap_r;
  logic [7:0]             gap_cnt_r;
  logic [COUNT_WIDTH-1:0] num_tx_r;
  logic [TW-1:0]          drain_timer_r;
  logic [COUNT_WIDTH:0]   result_sum_s;
  logic [COUNT_WIDTH:0]   sent_ext_s;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // One bit wider so the drain completion compare cannot wrap.
  assign result_sum_s = {1'b0, ok_count} + {1'b0, fail_count};
  assign sent_ext_s   = {1'b0, sent_count};

  // Run-control FSM with all request, status and counter outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      lfsr_r        <= 32'd1;
      gap_r         <= 8'd0;
      gap_cnt_r     <= 8'd0;
      num_tx_r      <= CNT_ZERO;
      drain_timer_r <= {TW{1'b0}};
      s_valid       <= 1'b0;
      s_payer       <= {USER_WIDTH{1'b0}};
      s_payee       <= {USER_WIDTH{1'b0}};
      s_amount      <= {BALANCE_WIDTH{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      sent_count    <= CNT_ZERO;
      ok_count      <= CNT_ZERO;
      fail_count    <= CNT_ZERO;
      err_timeout   <= 1'b0;
      err_stray     <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (m_valid) err_stray <= 1'b1;
          if (start) begin
            sent_count  <= CNT_ZERO;
            ok_count    <= CNT_ZERO;
            fail_count  <= CNT_ZERO;
            err_timeout <= 1'b0;
            err_stray   <= m_valid;
            if (num_tx != CNT_ZERO) begin
              lfsr_r    <= (seed == 32'd0) ? 32'd1 : seed;
              gap_r     <= gap;
              gap_cnt_r <= 8'd0;
              num_tx_r  <= num_tx;
              busy      <= 1'b1;
              state_r   <= ST_RUN;
            end else begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (m_valid) begin
            if (m_success) ok_count <= sat_inc(ok_count);
            else           fail_count <= sat_inc(fail_count);
          end
          if (sent_count == num_tx_r) begin
            drain_timer_r <= {TW{1'b0}};
            state_r       <= ST_DRAIN;
          end else begin
            if (gap_cnt_r == 8'd0) begin
              s_valid    <= 1'b1;
              s_payer    <= lfsr_r[USER_WIDTH-1:0];
              s_payee    <= lfsr_r[2*USER_WIDTH-1:USER_WIDTH];
              s_amount   <= {{(BALANCE_WIDTH-AMOUNT_BITS){1'b0}}, lfsr_r[31:32-AMOUNT_BITS]};
              lfsr_r     <= lfsr_next(lfsr_r);
              sent_count <= sat_inc(sent_count);
              gap_cnt_r  <= gap_r;
            end else begin
              gap_cnt_r <= gap_cnt_r - 8'd1;
            end
            // An abort coinciding with an issue lets that issue go out first.
            if (abort) begin
              drain_timer_r <= {TW{1'b0}};
              state_r       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (m_valid) begin
            if (m_success) ok_count <= sat_inc(ok_count);
            else           fail_count <= sat_inc(fail_count);
          end
          if (result_sum_s == sent_ext_s) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else if (m_valid) begin
            drain_timer_r <= {TW{1'b0}};
          end else if (drain_timer_r == TIMER_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            drain_timer_r <= drain_timer_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          if (m_valid) err_stray <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ledger_tx_driver.sv
// Directed and randomized runs of ledger_tx_driver against a 2-cycle ledger responder
// and a transfer-level reference model.
module tb_ledger_tx_driver;
  localparam int UW = 10;
  localparam int BW = 64;
  localparam int AB = 12;
  localparam int CW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst, start, abort, m_valid, m_success;
  logic [CW-1:0] num_tx;
  logic [7:0]    gap;
  logic [31:0]   seed;
  logic          s_valid, busy, done, err_timeout, err_stray;
  logic [UW-1:0] s_payer, s_payee;
  logic [BW-1:0] s_amount;
  logic [CW-1:0] sent_count, ok_count, fail_count;

  ledger_tx_driver #(.USER_WIDTH(UW), .BALANCE_WIDTH(BW), .AMOUNT_BITS(AB),
                     .COUNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tx(num_tx), .gap(gap),
    .seed(seed), .s_valid(s_valid), .s_payer(s_payer), .s_payee(s_payee),
    .s_amount(s_amount), .m_valid(m_valid), .m_success(m_success), .busy(busy),
    .done(done), .sent_count(sent_count), .ok_count(ok_count), .fail_count(fail_count),
    .err_timeout(err_timeout), .err_stray(err_stray));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int due_q[$];
  bit succ_q[$];
  int resp_mode = 0;  // 0 silent, 1 always success, 2 random
  bit counting = 0, stray_pulse = 0, seen_done = 0;
  int exp_ok, exp_fail, n_issued, last_issue, first_issue, done_cyc, start_cyc, cur_gap;
  logic [31:0] model_lfsr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // One clock: observe DUT just after the edge, then drive the ledger response for this cycle.
  task automatic tick();
    bit sb;
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1 && !seen_done) begin
      seen_done = 1'b1;
      done_cyc  = cyc;
    end
    if (s_valid === 1'b1) begin
      check("payer", 64'(s_payer), 64'(model_lfsr[UW-1:0]));
      check("payee", 64'(s_payee), 64'(model_lfsr[2*UW-1:UW]));
      check("amount", s_amount, 64'(model_lfsr[31:32-AB]));
      check("busy_in_run", 64'(busy), 64'd1);
      if (n_issued > 0) check("spacing", 64'(cyc - last_issue), 64'(cur_gap + 1));
      else first_issue = cyc;
      last_issue = cyc;
      n_issued++;
      model_lfsr = lfsr_step(model_lfsr);
      if (resp_mode != 0) begin
        due_q.push_back(cyc + 2);
        sb = (resp_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        succ_q.push_back(sb);
      end
    end
    m_valid   = 1'b0;
    m_success = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      m_valid   = 1'b1;
      m_success = succ_q[0];
      if (counting) begin
        if (succ_q[0]) exp_ok++;
        else exp_fail++;
      end
      void'(due_q.pop_front());
      void'(succ_q.pop_front());
    end
    if (stray_pulse) begin
      m_valid     = 1'b1;
      m_success   = 1'b1;
      stray_pulse = 1'b0;
    end
  endtask

  task automatic do_run(input string tag, input int num, input int g, input logic [31:0] sd,
                        input int rmode, input int abort_at, input int exp_sent,
                        input bit exp_to);
    cur_gap    = g;
    resp_mode  = rmode;
    model_lfsr = (sd == 32'd0) ? 32'd1 : sd;
    n_issued   = 0;
    exp_ok     = 0;
    exp_fail   = 0;
    seen_done  = 1'b0;
    counting   = 1'b1;
    num_tx = CW'(num);
    gap    = 8'(g);
    seed   = sd;
    start  = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      abort = (abort_at > 0 && n_issued == abort_at - 1);
      tick();
    end
    abort = 1'b0;
    check({tag, " done_seen"}, 64'(seen_done), 64'd1);
    if (num > 0) check({tag, " first_latency"}, 64'(first_issue - start_cyc), 64'd1);
    else check({tag, " done_latency"}, 64'(done_cyc - start_cyc), 64'd0);
    check({tag, " issued"}, 64'(n_issued), 64'(exp_sent));
    check({tag, " sent_count"}, 64'(sent_count), 64'(exp_sent));
    check({tag, " ok_count"}, 64'(ok_count), 64'(exp_ok));
    check({tag, " fail_count"}, 64'(fail_count), 64'(exp_fail));
    check({tag, " err_timeout"}, 64'(err_timeout), 64'(exp_to));
    check({tag, " err_stray"}, 64'(err_stray), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    if (exp_to) check({tag, " drain_len"}, 64'(done_cyc - last_issue), 64'(TO + 1));
    tick();
    check({tag, " done_pulse_end"}, 64'(done), 64'd0);
    counting = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " s_valid"}, 64'(s_valid), 64'd0);
    check({tag, " s_fields"}, 64'({s_payer, s_payee}) | s_amount, 64'd0);
    check({tag, " counts"}, 64'(sent_count | ok_count | fail_count), 64'd0);
    check({tag, " errs"}, 64'({err_timeout, err_stray}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_valid = 1'b0; m_success = 1'b0;
    num_tx = '0; gap = 8'd0; seed = 32'd0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    do_run("t1", 1, 0, 32'd1, 1, 0, 1, 1'b0);
    check("t1 payer", 64'(s_payer), 64'd1);
    check("t1 payee", 64'(s_payee), 64'd0);
    check("t1 amount", s_amount, 64'd0);
    check("t1 ok", 64'(ok_count), 64'd1);

    do_run("t2", 100, 0, 32'h1234_5678, 2, 0, 100, 1'b0);
    check("t2 total", 64'(ok_count + fail_count), 64'd100);
    do_run("t3", 4, 3, 32'hCAFE_F00D, 2, 0, 4, 1'b0);
    do_run("t4", 10, 0, 32'hDEAD_BEEF, 0, 0, 10, 1'b1);
    do_run("t5", 50, 0, 32'h0BAD_5EED, 2, 5, 5, 1'b0);
    do_run("seed0", 3, 1, 32'd0, 1, 0, 3, 1'b0);
    do_run("t6", 0, 0, 32'd7, 1, 0, 0, 1'b0);

    stray_pulse = 1'b1;
    tick();
    tick();
    check("t6 err_stray", 64'(err_stray), 64'd1);

    for (int r = 0; r < 3; r++) begin
      int n, g;
      n = $urandom_range(1, 30);
      g = $urandom_range(0, 4);
      do_run("rand", n, g, $urandom, 2, 0, n, 1'b0);
    end

    // Reset mid-run: results still in flight must land as strays.
    resp_mode = 2; cur_gap = 0; n_issued = 0; seen_done = 1'b0;
    model_lfsr = 32'h0000_00A5;
    num_tx = 32'd20; gap = 8'd0; seed = 32'h0000_00A5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    for (int k = 0; k < 4; k++) tick();
    check("midrst err_stray", 64'(err_stray), 64'd1);
    check("midrst sent", 64'(sent_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
